fsab_mem_responder: RTL

Memory-side endpoint of the FSAB request bus. It accepts the single serialized request stream that the FSAB arbiter drives (fsabo_*), buffers the commands and write data, and executes them against an internal synchronous RAM. It returns read data on the fsabi_* return bus and issues one fsabo_credit pulse per completed transaction, which replenishes the arbiter's credit counter. It serves as the behavioural memory model for system simulation and as the template for the DDR-facing responder.

---
 rtl/fsab_mem_responder.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fsab_mem_responder.sv
// FSAB memory-side responder: queues serialized requests and executes them against
// an internal synchronous RAM, returning read beats and one credit per transaction.
module fsab_mem_responder #(
   parameter int FSAB_INITIAL_CREDITS = 4,
   parameter int FSAB_MAX_LEN         = 8,
   parameter int DATA_W               = 64,
   parameter int ADDR_W               = 31,
   parameter int LEN_W                = 4,
   parameter int DID_W                = 4,
   parameter int MEM_WORDS            = 1024
) (
   input  logic                clk,
   input  logic                rst_b,
   input  logic                fsabo_valid,
   input  logic                fsabo_mode,
   input  logic [DID_W-1:0]    fsabo_did,
   input  logic [DID_W-1:0]    fsabo_subdid,
   input  logic [ADDR_W-1:0]   fsabo_addr,
   input  logic [LEN_W-1:0]    fsabo_len,
   input  logic [DATA_W-1:0]   fsabo_data,
   input  logic [DATA_W/8-1:0] fsabo_mask,
   output logic                fsabo_credit,
   output logic                fsabi_valid,
   output logic [DID_W-1:0]    fsabi_did,
   output logic [DID_W-1:0]    fsabi_subdid,
   output logic [DATA_W-1:0]   fsabi_data,
   output logic                proto_err
);
   localparam int BYTES = DATA_W / 8;
   localparam int BSH   = $clog2(BYTES);
   localparam int IW    = $clog2(MEM_WORDS);
   localparam int CQ    = FSAB_INITIAL_CREDITS;
   localparam int DQ    = FSAB_INITIAL_CREDITS * FSAB_MAX_LEN;
   localparam int CPW   = $clog2(CQ);
   localparam int DPW   = $clog2(DQ);
   localparam int OCW   = $clog2(CQ + 1);

   typedef struct packed {
      logic             mode;
      logic [DID_W-1:0] did;
      logic [DID_W-1:0] subdid;
      logic [IW-1:0]    idx;
      logic [LEN_W-1:0] len;
   } cmd_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [BYTES-1:0]  mask;
   } wd_t;

   typedef enum logic {I_HDR, I_WDATA} intake_t;
   typedef enum logic [1:0] {E_IDLE, E_RD, E_WR, E_DONE} engine_t;

   logic [DATA_W-1:0] mem [MEM_WORDS];

   // ---------------- intake ----------------
   intake_t          in_state;
   logic [LEN_W-1:0] wr_left;
   logic             wr_drop;
   cmd_t             wr_cmd;
   logic [OCW-1:0]   outstanding;

   logic [LEN_W-1:0] len_eff;
   logic             hdr_bad, hdr_beat, dat_beat, accept, hdr_take;
   cmd_t             hdr_cmd, cmd_in;
   logic             cmd_push, wd_push;
   wd_t              wd_in;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^{fsabo_addr[ADDR_W-1:BSH+IW], fsabo_addr[BSH-1:0]};

   always_comb begin
      hdr_bad = (fsabo_len == '0) || (fsabo_len > LEN_W'(FSAB_MAX_LEN));
      len_eff = fsabo_len;
      if (fsabo_len == '0)
         len_eff = LEN_W'(1);
      else if (fsabo_len > LEN_W'(FSAB_MAX_LEN))
         len_eff = LEN_W'(FSAB_MAX_LEN);
   end

   // Admission is decided against outstanding credits, so a credit returned this
   // cycle frees its slot for a header arriving in the same cycle.
   assign accept   = (outstanding < OCW'(CQ)) || fsabo_credit;
   assign hdr_beat = (in_state == I_HDR) && fsabo_valid;
   assign dat_beat = (in_state == I_WDATA) && fsabo_valid;
   assign hdr_take = hdr_beat && accept;

   assign hdr_cmd = '{mode: fsabo_mode, did: fsabo_did, subdid: fsabo_subdid,
                      idx: fsabo_addr[BSH +: IW], len: len_eff};
   assign cmd_in  = (in_state == I_HDR) ? hdr_cmd : wr_cmd;
   assign wd_in   = '{data: fsabo_data, mask: fsabo_mask};

   assign cmd_push = (hdr_take && (!fsabo_mode || len_eff == LEN_W'(1)))
                   || (dat_beat && !wr_drop && wr_left == LEN_W'(1));
   assign wd_push  = (hdr_take && fsabo_mode) || (dat_beat && !wr_drop);

   // ---------------- queues ----------------
   cmd_t           cmd_mem [CQ];
   logic [CPW-1:0] cmd_wp, cmd_rp;
   logic [CPW:0]   cmd_cnt;
   logic           cmd_pop, cmd_empty, cmd_full, cmd_push_ok;
   cmd_t           cmd_head;

   wd_t            wd_mem [DQ];
   logic [DPW-1:0] wd_wp, wd_rp;
   logic [DPW:0]   wd_cnt;
   logic           wd_pop, wd_full, wd_push_ok;
   wd_t            wd_head;

   assign cmd_empty   = (cmd_cnt == '0);
   assign cmd_full    = (cmd_cnt == (CPW+1)'(CQ));
   assign cmd_push_ok = cmd_push && (!cmd_full || cmd_pop);
   assign cmd_head    = cmd_mem[cmd_rp];
   assign wd_full     = (wd_cnt == (DPW+1)'(DQ));
   assign wd_push_ok  = wd_push && (!wd_full || wd_pop);
   assign wd_head     = wd_mem[wd_rp];

   always_ff @(posedge clk) begin
      if (cmd_push_ok) cmd_mem[cmd_wp] <= cmd_in;
      if (wd_push_ok)  wd_mem[wd_wp]   <= wd_in;
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         cmd_wp <= '0; cmd_rp <= '0; cmd_cnt <= '0;
         wd_wp  <= '0; wd_rp  <= '0; wd_cnt  <= '0;
      end else begin
         if (cmd_push_ok) cmd_wp <= (cmd_wp == CPW'(CQ-1)) ? '0 : cmd_wp + 1'b1;
         if (cmd_pop)     cmd_rp <= (cmd_rp == CPW'(CQ-1)) ? '0 : cmd_rp + 1'b1;
         cmd_cnt <= cmd_cnt + (CPW+1)'(cmd_push_ok) - (CPW+1)'(cmd_pop);
         if (wd_push_ok)  wd_wp <= (wd_wp == DPW'(DQ-1)) ? '0 : wd_wp + 1'b1;
         if (wd_pop)      wd_rp <= (wd_rp == DPW'(DQ-1)) ? '0 : wd_rp + 1'b1;
         wd_cnt <= wd_cnt + (DPW+1)'(wd_push_ok) - (DPW+1)'(wd_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         in_state    <= I_HDR;
         wr_left     <= '0;
         wr_drop     <= 1'b0;
         wr_cmd      <= '0;
         outstanding <= '0;
         proto_err   <= 1'b0;
      end else begin
         outstanding <= outstanding + OCW'(hdr_take) - OCW'(fsabo_credit);
         if ((hdr_beat && (hdr_bad || !accept)) || (cmd_push && !cmd_push_ok)
             || (wd_push && !wd_push_ok))
            proto_err <= 1'b1;
         case (in_state)
            I_HDR: if (hdr_beat && fsabo_mode && len_eff != LEN_W'(1)) begin
               in_state <= I_WDATA;
               wr_left  <= len_eff - LEN_W'(1);
               wr_drop  <= !accept;
               wr_cmd   <= hdr_cmd;
            end
            I_WDATA: if (dat_beat) begin
               wr_left <= wr_left - LEN_W'(1);
               if (wr_left == LEN_W'(1)) in_state <= I_HDR;
            end
            default: in_state <= I_HDR;
         endcase
      end
   end

   // ---------------- engine ----------------
   engine_t          eng;
   logic [IW-1:0]    cur_idx, issue_idx;
   logic [DID_W-1:0] cur_did, cur_subdid, issue_did, issue_subdid;
   logic [LEN_W-1:0] left;
   logic             start, issue_rd, issue_wr;
   logic [BYTES-1:0] byte_we;

   // DONE can launch the next command, so back-to-back transactions stay gapless.
   assign start        = ((eng == E_IDLE) || (eng == E_DONE)) && !cmd_empty;
   assign cmd_pop      = start;
   assign issue_rd     = (start && !cmd_head.mode) || (eng == E_RD);
   assign issue_wr     = (start && cmd_head.mode) || (eng == E_WR);
   assign wd_pop       = issue_wr;
   assign issue_idx    = start ? cmd_head.idx    : cur_idx;
   assign issue_did    = start ? cmd_head.did    : cur_did;
   assign issue_subdid = start ? cmd_head.subdid : cur_subdid;

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         eng          <= E_IDLE;
         fsabo_credit <= 1'b0;
         cur_idx      <= '0;
         cur_did      <= '0;
         cur_subdid   <= '0;
         left         <= '0;
      end else begin
         fsabo_credit <= (eng == E_DONE);
         if (start) begin
            cur_idx    <= cmd_head.idx + 1'b1;
            cur_did    <= cmd_head.did;
            cur_subdid <= cmd_head.subdid;
            left       <= cmd_head.len - LEN_W'(1);
            if (cmd_head.len == LEN_W'(1)) eng <= E_DONE;
            else                          eng <= cmd_head.mode ? E_WR : E_RD;
         end else begin
            case (eng)
               E_RD, E_WR: begin
                  cur_idx <= cur_idx + 1'b1;
                  left    <= left - LEN_W'(1);
                  if (left == LEN_W'(1)) eng <= E_DONE;
               end
               E_DONE:  eng <= E_IDLE;
               default: eng <= E_IDLE;
            endcase
         end
      end
   end

   generate
      for (genvar gi = 0; gi < BYTES; gi++) begin : g_we
         assign byte_we[gi] = rst_b && issue_wr && wd_head.mask[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int b = 0; b < BYTES; b++)
         if (byte_we[b]) mem[issue_idx][b*8 +: 8] <= wd_head.data[b*8 +: 8];
   end

   // The output register doubles as the RAM read register; idle cycles force zeros.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         fsabi_valid  <= 1'b0;
         fsabi_did    <= '0;
         fsabi_subdid <= '0;
         fsabi_data   <= '0;
      end else begin
         fsabi_valid  <= issue_rd;
         fsabi_did    <= issue_rd ? issue_did    : '0;
         fsabi_subdid <= issue_rd ? issue_subdid : '0;
         fsabi_data   <= issue_rd ? mem[issue_idx] : '0;
      end
   end
endmodule
